// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds, synchronous flush and support for
//   depths that are not a power of two.
//
// Build option:
//   FIFO_FWFT_EN  - when defined, the head word is presented combinationally
//                   on o_data_out (first-word-fall-through, 0 when empty).
//                   When undefined, o_data_out is registered and updated one
//                   cycle after an accepted read.
//
// Ports:
//   i_clk          clock, all logic on the rising edge
//   i_rst          synchronous active-high reset (priority over i_flush)
//   i_flush        synchronous clear of pointers, count and status pulses
//   i_data_in      write data
//   i_wr_en        write request
//   i_rd_en        read request
//   o_data_out     read data
//   o_wr_ack       registered pulse: previous-cycle write accepted
//   o_overflow     registered pulse: previous-cycle write rejected (full)
//   o_underflow    registered pulse: previous-cycle read rejected (empty)
//   o_full         count == FIFO_DEPTH
//   o_empty        count == 0
//   o_almostfull   free slots <= AFULL_THRESH and not full
//   o_almostempty  count <= AEMPTY_THRESH and not empty
//   o_data_count   current occupancy
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush,
  input  logic [FIFO_WIDTH-1:0]           i_data_in,
  input  logic                            i_wr_en,
  input  logic                            i_rd_en,
  output logic [FIFO_WIDTH-1:0]           o_data_out,
  output logic                            o_wr_ack,
  output logic                            o_overflow,
  output logic                            o_underflow,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_almostfull,
  output logic                            o_almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_data_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);
  // almostfull threshold expressed as an occupancy level
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(FIFO_DEPTH - AFULL_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_THRESH);

  // Elaboration-time parameter legality
  generate
    if ((FIFO_WIDTH < 1) || (FIFO_DEPTH < 2) ||
        (AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH - 1) ||
        (AEMPTY_THRESH < 1) || (AEMPTY_THRESH > FIFO_DEPTH - 1)) begin : g_bad_param
      $error("sync_fifo_param: illegal parameter combination");
    end
  endgenerate

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_do;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  assign w_full   = (r_count == CNT_MAX);
  assign w_empty  = (r_count == {CNT_W{1'b0}});
  assign w_wr_acc = i_wr_en & ~w_full;
  assign w_rd_acc = i_rd_en & ~w_empty;
  // storage is only written when the write really takes effect this edge
  assign w_wr_do  = w_wr_acc & ~i_rst & ~i_flush;

  // Pointer successors: explicit wrap at DEPTH-1 so odd depths work
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
    if (r_wr_ptr == PTR_LAST) begin
      w_wr_ptr_nxt = {PTR_W{1'b0}};
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    end
    if (r_rd_ptr == PTR_LAST) begin
      w_rd_ptr_nxt = {PTR_W{1'b0}};
    end else begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage array write port (contents are intentionally never reset)
  always_ff @(posedge i_clk) begin
    if (w_wr_do) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // Pointers, occupancy and the registered status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= i_wr_en & w_full;
      r_underflow <= i_rd_en & w_empty;
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through combinationally; zero while empty
  always_comb begin
    o_data_out = {FIFO_WIDTH{1'b0}};
    if (w_empty) begin
      o_data_out = {FIFO_WIDTH{1'b0}};
    end else begin
      o_data_out = r_mem[r_rd_ptr];
    end
  end
`else
  logic [FIFO_WIDTH-1:0] r_data_out;

  // Registered read data: cleared by reset, held through flush and idle cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_out <= {FIFO_WIDTH{1'b0}};
    end else if (!i_flush && w_rd_acc) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign o_data_out = r_data_out;
`endif

  assign o_wr_ack      = r_wr_ack;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almostfull  = ~w_full & (r_count >= CNT_AF);
  assign o_almostempty = ~w_empty & (r_count <= CNT_AE);
  assign o_data_count  = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Drives a depth-8 and a depth-5 FIFO with identical stimulus. Each DUT has
//   its own occupancy model and queue scoreboard; after every clock edge all
//   outputs of both DUTs are compared with the model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DEP [2] = '{8, 5};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] din = 16'h0000;

  logic [15:0] dout8, dout5;
  logic        ack8, ov8, un8, full8, empty8, af8, ae8;
  logic        ack5, ov5, un5, full5, empty5, af5, ae5;
  logic [3:0]  cnt8;
  logic [2:0]  cnt5;

  int n_cmp = 0;
  int n_err = 0;

  int          m      [2];
  logic [15:0] e_dout [2];
  logic        e_ack  [2];
  logic        e_ov   [2];
  logic        e_un   [2];
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];
  logic [15:0] wdata;

  always #5 clk = ~clk;

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AFULL_THRESH(1), .AEMPTY_THRESH(1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_data_in(din),
    .i_wr_en(wr_en), .i_rd_en(rd_en), .o_data_out(dout8),
    .o_wr_ack(ack8), .o_overflow(ov8), .o_underflow(un8),
    .o_full(full8), .o_empty(empty8), .o_almostfull(af8),
    .o_almostempty(ae8), .o_data_count(cnt8)
  );

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AFULL_THRESH(1), .AEMPTY_THRESH(1)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_data_in(din),
    .i_wr_en(wr_en), .i_rd_en(rd_en), .o_data_out(dout5),
    .o_wr_ack(ack5), .o_overflow(ov5), .o_underflow(un5),
    .o_full(full5), .o_empty(empty5), .o_almostfull(af5),
    .o_almostempty(ae5), .o_data_count(cnt5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string       s;
      logic [31:0] o_cnt, o_dout;
      logic        o_ack, o_ov, o_un, o_full, o_empty, o_af, o_ae;
      logic        x_full, x_empty;
      s       = (k == 0) ? "d8" : "d5";
      o_cnt   = (k == 0) ? 32'(cnt8) : 32'(cnt5);
      o_dout  = (k == 0) ? 32'(dout8) : 32'(dout5);
      o_ack   = (k == 0) ? ack8   : ack5;
      o_ov    = (k == 0) ? ov8    : ov5;
      o_un    = (k == 0) ? un8    : un5;
      o_full  = (k == 0) ? full8  : full5;
      o_empty = (k == 0) ? empty8 : empty5;
      o_af    = (k == 0) ? af8    : af5;
      o_ae    = (k == 0) ? ae8    : ae5;
      x_full  = (m[k] == DEP[k]);
      x_empty = (m[k] == 0);
      chk({s, "_count"},       o_cnt,          32'(m[k]));
      chk({s, "_full"},        32'(o_full),    32'(x_full));
      chk({s, "_empty"},       32'(o_empty),   32'(x_empty));
      chk({s, "_almostfull"},  32'(o_af),      32'(!x_full && (DEP[k] - m[k]) <= 1));
      chk({s, "_almostempty"}, 32'(o_ae),      32'(!x_empty && m[k] <= 1));
      chk({s, "_wr_ack"},      32'(o_ack),     32'(e_ack[k]));
      chk({s, "_overflow"},    32'(o_ov),      32'(e_ov[k]));
      chk({s, "_underflow"},   32'(o_un),      32'(e_un[k]));
      chk({s, "_data_out"},    o_dout,         32'(e_dout[k]));
    end
  endtask

  // One clock cycle of stimulus; models both FIFOs and checks everything after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic fl, input logic rs,
                     input logic [15:0] d);
    logic wa [2];
    logic ra [2];
    logic fu [2];
    logic em [2];
    for (int k = 0; k < 2; k++) begin
      fu[k] = (m[k] == DEP[k]);
      em[k] = (m[k] == 0);
      wa[k] = wr && !fu[k];
      ra[k] = rd && !em[k];
    end
    wr_en = wr; rd_en = rd; flush = fl; rst = rs; din = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (rs || fl) begin
        if (k == 0) sb0.delete(); else sb1.delete();
        m[k]     = 0;
        e_ack[k] = 1'b0;
        e_ov[k]  = 1'b0;
        e_un[k]  = 1'b0;
        if (rs) e_dout[k] = 16'h0000;
      end else begin
        e_ack[k] = wa[k];
        e_ov[k]  = wr && fu[k];
        e_un[k]  = rd && em[k];
        if (ra[k]) e_dout[k] = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        if (wa[k]) begin
          if (k == 0) sb0.push_back(d); else sb1.push_back(d);
        end
        m[k] = m[k] + int'(wa[k]) - int'(ra[k]);
      end
`ifdef FIFO_FWFT_EN
      if (k == 0) e_dout[k] = (sb0.size() > 0) ? sb0[0] : 16'h0000;
      else        e_dout[k] = (sb1.size() > 0) ? sb1[0] : 16'h0000;
`endif
    end
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m[k] = 0; e_dout[k] = 16'h0000; e_ack[k] = 1'b0; e_ov[k] = 1'b0; e_un[k] = 1'b0;
    end
    wdata = 16'h2000;

    // 1: reset for two cycles with a write request pending
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF);

    // 2: eight writes, then a ninth into a full FIFO
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000 + 16'(i));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hDEAD);

    // 3: drain, then one read too many
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // 4: simultaneous read/write at count 3, at full and at empty
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000 + 16'(i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h3003);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h3010 + 16'(i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h3020);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h3030);

    // 5: interleaved traffic at random fill levels (wraps the depth-5 pointers)
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int p = 0; p < 23; p++) begin
      int tgt;
      tgt = int'($urandom_range(0, 5));
      while (m[1] < tgt) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, wdata);
        wdata = wdata + 16'h0001;
      end
      while (m[1] > tgt) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, wdata);
      wdata = wdata + 16'h0001;
    end

    // 6: flush at count 4 (requests ignored), refill to 6, then reset
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h4000 + 16'(i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h4444);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h5000 + 16'(i));
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h5555);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
